word_byte_serializer: RTL and testbench



---
 rtl/word_byte_serializer.sv | 81 ++++++++
 tb/tb_word_byte_serializer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/word_byte_serializer.sv
// Word-to-byte serializer: captures one word per input handshake and emits up to
// BYTES bytes from it, one per output handshake, flagging the final byte with out_last.
module word_byte_serializer #(
    parameter int BYTES     = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter int LW        = $clog2(BYTES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*BYTES-1:0] in_data,
    input  logic [LW-1:0]      in_len,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_data,
    output logic               out_last,
    output logic               busy,
    output logic               state_dbg
);

    // Handshake rule on both ports: a transfer happens on the rising edge where
    // valid && ready are both 1; valid never waits on ready, and a presented
    // byte (data/last) is held unchanged until it is transferred.

    localparam int IW = $clog2(BYTES);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state_q;
    logic [8*BYTES-1:0]  word_q;
    logic [LW-1:0]       cnt_q;
    logic [IW-1:0]       idx_q;
    logic [LW-1:0]       eff_len;
    logic                in_accept;
    logic                out_accept;

    // Lengths of 0 or above BYTES fall back to a full word.
    always_comb begin
        eff_len = in_len;
        if (in_len == '0 || in_len > LW'(BYTES))
            eff_len = LW'(BYTES);
    end

    // Ready combinationally follows out_ready on the final byte so the next
    // word can load on the same edge, giving gap-free word-to-word streaming.
    assign in_ready   = !rst && (state_q == IDLE || (cnt_q == LW'(1) && out_ready));
    assign in_accept  = in_valid && in_ready;
    assign out_accept = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else if (in_accept) begin
            state_q <= SEND;
            word_q  <= in_data;
            cnt_q   <= eff_len;
            idx_q   <= MSB_FIRST ? IW'(BYTES - 1) : '0;
        end else if (out_accept) begin
            if (cnt_q > LW'(1)) begin
                cnt_q <= cnt_q - LW'(1);
                idx_q <= MSB_FIRST ? idx_q - IW'(1) : idx_q + IW'(1);
            end else begin
                state_q <= IDLE;
            end
        end
    end

    assign out_valid = (state_q == SEND);
    assign out_data  = word_q[8*idx_q +: 8];
    assign out_last  = (state_q == SEND) && (cnt_q == LW'(1));
    assign busy      = out_valid;
    assign state_dbg = (state_q == SEND);

endmodule

// File: tb/tb_word_byte_serializer.sv
// Bench for word_byte_serializer: an MSB-first and an LSB-first instance share
// stimulus and are scored against per-instance queues of expected bytes.
module tb_word_byte_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic [2:0]  in_len;
    logic        out_ready;

    logic        m_in_ready, m_out_valid, m_out_last, m_busy, m_state_dbg;
    logic [7:0]  m_out_data;
    logic        l_in_ready, l_out_valid, l_out_last, l_busy, l_state_dbg;
    logic [7:0]  l_out_data;

    // {last, byte} per expected output beat
    logic [8:0]  exp_q_m[$];
    logic [8:0]  exp_q_l[$];
    logic        clean;
    int          chk_cnt = 0;
    int          err_cnt = 0;

    always #5 clk = ~clk;

    word_byte_serializer #(.BYTES(4), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_data(in_data), .in_len(in_len), .out_valid(m_out_valid),
        .out_ready(out_ready), .out_data(m_out_data), .out_last(m_out_last),
        .busy(m_busy), .state_dbg(m_state_dbg)
    );

    word_byte_serializer #(.BYTES(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(l_in_ready),
        .in_data(in_data), .in_len(in_len), .out_valid(l_out_valid),
        .out_ready(out_ready), .out_data(l_out_data), .out_last(l_out_last),
        .busy(l_busy), .state_dbg(l_state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_dut(input string tag, input logic ir, input logic ov,
                             input logic [7:0] od, input logic ol, input logic bz,
                             input logic sd, input int sz, input logic [8:0] head);
        logic exp_ir;
        exp_ir = !rst && (sz == 0 || (sz == 1 && out_ready));
        check({tag, ".in_ready"}, 32'(ir), 32'(exp_ir));
        check({tag, ".out_valid"}, 32'(ov), 32'(sz != 0));
        check({tag, ".busy"}, 32'(bz), 32'(sz != 0));
        check({tag, ".state"}, 32'(sd), 32'(sz != 0));
        if (sz != 0) begin
            check({tag, ".out_data"}, 32'(od), 32'(head[7:0]));
            check({tag, ".out_last"}, 32'(ol), 32'(head[8]));
        end else begin
            check({tag, ".out_last_idle"}, 32'(ol), 32'd0);
            if (clean)
                check({tag, ".out_data_rst"}, 32'(od), 32'd0);
        end
    endtask

    // One clock cycle: drive inputs, check at negedge, then advance the model.
    task automatic step(input logic v, input logic [31:0] d, input logic [2:0] l,
                        input logic ordy, input logic r);
        int   eff;
        int   sz;
        logic fire_in;
        logic fire_out;
        in_valid  = v;
        in_data   = d;
        in_len    = l;
        out_ready = ordy;
        rst       = r;
        @(negedge clk);
        check_dut("msb", m_in_ready, m_out_valid, m_out_data, m_out_last, m_busy,
                  m_state_dbg, exp_q_m.size(), exp_q_m.size() != 0 ? exp_q_m[0] : 9'h0);
        check_dut("lsb", l_in_ready, l_out_valid, l_out_data, l_out_last, l_busy,
                  l_state_dbg, exp_q_l.size(), exp_q_l.size() != 0 ? exp_q_l[0] : 9'h0);
        sz       = exp_q_m.size();
        fire_out = (sz != 0) && ordy;
        fire_in  = v && !r && (sz == 0 || (sz == 1 && ordy));
        if (r) begin
            exp_q_m.delete();
            exp_q_l.delete();
            clean = 1'b1;
        end else begin
            if (fire_out) begin
                void'(exp_q_m.pop_front());
                void'(exp_q_l.pop_front());
            end
            if (fire_in) begin
                eff   = (l == 0 || l > 4) ? 4 : int'(l);
                clean = 1'b0;
                for (int k = 0; k < eff; k++) begin
                    exp_q_m.push_back({k == eff - 1, d[8*(3-k) +: 8]});
                    exp_q_l.push_back({k == eff - 1, d[8*k +: 8]});
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_len    = '0;
        out_ready = 1'b0;
        clean     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        step(0, 32'h0, 0, 1, 1);

        // Single full word
        step(1, 32'hA1B2C3D4, 4, 1, 0);
        repeat (4) step(0, 32'h0, 0, 1, 0);
        step(0, 32'h0, 0, 1, 0);

        // Back-to-back, second word of length 2, in_valid held
        step(1, 32'h11223344, 4, 1, 0);
        repeat (4) step(1, 32'h55667788, 2, 1, 0);
        repeat (2) step(0, 32'h0, 0, 1, 0);

        // Backpressure on the second byte with a competing word offered
        step(1, 32'hA1B2C3D4, 4, 1, 0);
        step(0, 32'h0, 0, 1, 0);
        repeat (3) step(1, 32'hDEADBEEF, 4, 0, 0);
        repeat (3) step(0, 32'hDEADBEEF, 4, 1, 0);
        step(0, 32'h0, 0, 1, 0);

        // Out-of-range lengths 0 and 5 fall back to full words
        step(1, 32'hA1B2C3D4, 0, 1, 0);
        repeat (4) step(0, 32'h0, 0, 1, 0);
        step(1, 32'hA1B2C3D4, 5, 1, 0);
        repeat (4) step(0, 32'h0, 0, 1, 0);

        // Length-1 word
        step(1, 32'hCAFEF00D, 1, 1, 0);
        step(0, 32'h0, 0, 1, 0);

        // Reset mid-word, then a clean restart
        step(1, 32'hA1B2C3D4, 4, 1, 0);
        step(0, 32'h0, 0, 1, 0);
        repeat (2) step(1, 32'h99999999, 4, 1, 1);
        step(1, 32'h01020304, 4, 1, 0);
        repeat (5) step(0, 32'h0, 0, 1, 0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
        end
        repeat (6) step(0, 32'h0, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule
